// File: rtl/nn_pkg.sv
// Shared neural-network definitions: layer sequencer state encoding and Q1.15 format constants.
package nn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int Q_FRAC     = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit shift register that delays a strobe by DEPTH cycles to match memory read latency.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | DEPTH'(i_valid);
    end
  end

  assign o_valid = r_sr[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// Time-multiplexes one neuron MAC over all outputs of a fully connected layer.
// Optional LAYER_SEQ_CYCLE_CNT_EN adds a 32-bit busy-cycle counter port (cycle_count).
module layer_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = nn_pkg::DATA_WIDTH,
  parameter int MEM_LAT     = 1,
  parameter int IN_AW       = $clog2(NUM_INPUTS),
  parameter int W_AW        = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int N_AW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IN_AW-1:0]      in_addr,
  output logic [W_AW-1:0]       w_addr,
  output logic [N_AW-1:0]       b_addr,
  output logic                  rd_en,
  output logic                  neuron_clr,
  output logic                  neuron_valid,
  input  logic                  neuron_out_valid,
  input  logic [DATA_WIDTH-1:0] neuron_data,
  output logic                  out_we,
  output logic [N_AW-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef LAYER_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  import nn_pkg::*;

  localparam logic [IN_AW-1:0] LAST_I = IN_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]  LAST_N = N_AW'(NUM_NEURONS - 1);

  seq_state_t            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_clr;
  logic                  r_rd;
  logic                  r_fin;
  logic [IN_AW-1:0]      r_i;
  logic [W_AW-1:0]       r_w;
  logic [N_AW-1:0]       r_n;
  logic                  r_we;
  logic [N_AW-1:0]       r_oaddr;
  logic [DATA_WIDTH-1:0] r_odata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b1;
      r_rd    <= 1'b0;
      r_fin   <= 1'b0;
      r_i     <= '0;
      r_w     <= '0;
      r_n     <= '0;
      r_we    <= 1'b0;
      r_oaddr <= '0;
      r_odata <= '0;
    end else begin
      r_clr  <= 1'b0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
            r_rd    <= 1'b1;
            r_i     <= '0;
            r_w     <= '0;
            r_n     <= '0;
          end
        end
        RUN: begin
          // w_addr keeps counting across the neuron boundary, so it is already n*NUM_INPUTS on re-entry
          r_w <= r_w + W_AW'(1);
          if (r_i == LAST_I) begin
            r_i     <= '0;
            r_rd    <= 1'b0;
            r_state <= WAIT;
          end else begin
            r_i <= r_i + IN_AW'(1);
          end
        end
        WAIT: begin
          // r_fin spends one cycle letting the final write land before done
          if (r_fin) begin
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (neuron_out_valid) begin
            r_we    <= 1'b1;
            r_oaddr <= r_n;
            r_odata <= neuron_data;
            if (r_n == LAST_N) begin
              r_fin <= 1'b1;
            end else begin
              r_n     <= r_n + N_AW'(1);
              r_rd    <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH(MEM_LAT)
  ) u_valid_delay (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_valid(r_rd),
    .o_valid(neuron_valid)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign in_addr    = r_i;
  assign w_addr     = r_w;
  assign b_addr     = r_n;
  assign rd_en      = r_rd;
  assign neuron_clr = r_clr;
  assign out_we     = r_we;
  assign out_addr   = r_oaddr;
  assign out_data   = r_odata;

`ifdef LAYER_SEQ_CYCLE_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_cnt <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cycle_count = r_cnt;
`endif

endmodule
